// File: rtl/csub_pipe.sv
// Two-stage pipelined complex subtractor p = a - b with valid/ready on both sides.
// Optional clamping to the input range and a sat flag are enabled by defining CSUB_SAT_EN.
module csub_pipe #(
  parameter int W  = 8,
  parameter int AW = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  ar,
  input  logic signed [W-1:0]  ai,
  input  logic signed [W-1:0]  br,
  input  logic signed [W-1:0]  bi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] pr,
`ifdef CSUB_SAT_EN
  output logic signed [AW-1:0] pi,
  output logic                 sat
`else
  output logic signed [AW-1:0] pi
`endif
);

  logic                 s1_v, s2_v;
  logic                 s1_ld, s2_ld;
  logic signed [W-1:0]  s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [AW-1:0] dr, di;
  logic signed [AW-1:0] res_r, res_i;

  assign s2_ld     = !s2_v | out_ready;
  assign s1_ld     = !s1_v | s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = s2_v;

  // Size casts of signed operands sign-extend before the subtraction.
  assign dr = AW'(s1_ar) - AW'(s1_br);
  assign di = AW'(s1_ai) - AW'(s1_bi);

`ifdef CSUB_SAT_EN
  localparam int XW = AW - W + 1;
  logic ovf_r, ovf_i;

  // Overflow when the bits above the input sign position disagree with the result sign.
  always_comb begin
    ovf_r = dr[AW-1:W-1] != {XW{dr[AW-1]}};
    ovf_i = di[AW-1:W-1] != {XW{di[AW-1]}};
    res_r = dr;
    res_i = di;
    if (ovf_r) res_r = {{XW{dr[AW-1]}}, {(W-1){~dr[AW-1]}}};
    if (ovf_i) res_i = {{XW{di[AW-1]}}, {(W-1){~di[AW-1]}}};
  end
`else
  assign res_r = dr;
  assign res_i = di;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s1_ar <= '0;
      s1_ai <= '0;
      s1_br <= '0;
      s1_bi <= '0;
      pr    <= '0;
      pi    <= '0;
`ifdef CSUB_SAT_EN
      sat   <= 1'b0;
`endif
    end else begin
      if (s1_ld) begin
        s1_v  <= in_valid;
        s1_ar <= ar;
        s1_ai <= ai;
        s1_br <= br;
        s1_bi <= bi;
      end
      if (s2_ld) begin
        s2_v <= s1_v;
        pr   <= res_r;
        pi   <= res_i;
`ifdef CSUB_SAT_EN
        sat  <= ovf_r | ovf_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_csub_pipe.sv
// Scoreboard bench for csub_pipe: driver pushes model results, negedge monitor pops and compares.
// Build with CSUB_SAT_EN defined to exercise the clamping configuration.
module tb_csub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [7:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [8:0] pr, pi;
  logic sat;

  always #5 clk = ~clk;

  csub_pipe #(.W(8), .AW(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ar       (ar),
    .ai       (ai),
    .br       (br),
    .bi       (bi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pr       (pr),
`ifdef CSUB_SAT_EN
    .pi       (pi),
    .sat      (sat)
`else
    .pi       (pi)
`endif
  );

`ifndef CSUB_SAT_EN
  assign sat = 1'b0;
`endif

  typedef struct {
    int r;
    int i;
    int s;
    int t;
    bit ex;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    lat_ex = 1'b0;
  bit    done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, inout int s);
    int r = v;
`ifdef CSUB_SAT_EN
    if (v > 127) begin r = 127; s = 1; end
    if (v < -128) begin r = -128; s = 1; end
`endif
    return r;
  endfunction

  task automatic send(input int a_r, input int a_i, input int b_r, input int b_i);
    item_t it;
    int    s = 0;
    ar = 8'(a_r);
    ai = 8'(a_i);
    br = 8'(b_r);
    bi = 8'(b_i);
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        it.r  = clampv(a_r - b_r, s);
        it.i  = clampv(a_i - b_i, s);
        it.s  = s;
        it.t  = cyc;
        it.ex = lat_ex;
        q.push_back(it);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        if (out_ready) chk("unexpected_out", int'(out_valid), 0);
      end else begin
        chk("pr", int'(pr), q[0].r);
        chk("pi", int'(pi), q[0].i);
`ifdef CSUB_SAT_EN
        chk("sat", int'(sat), q[0].s);
`endif
        if (out_ready) begin
          if (q[0].ex) chk("latency", cyc - q[0].t, 2);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pr", int'(pr), 0);
    chk("rst_pi", int'(pi), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Basic and extreme operands with exact latency.
    lat_ex = 1'b1;
    send(24, 36, 16, -8);
    send(-128, -128, 127, 127);
    drain();

    // Back-to-back stream; exact latency on every item implies no bubbles.
    for (int k = 0; k < 16; k++) send(k, 0, 0, -k);
    drain();
    lat_ex = 1'b0;

    // Backpressure: two buffered, third stalls, released together.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        send(10, -20, 3, 4);
        send(-50, 60, 70, -80);
        send(127, -128, -128, 127);
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_accepted", q.size(), 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
      end
    join
    drain();

    // Mid-stream reset with both stages full.
    out_ready = 1'b0;
    send(1, 2, 3, 4);
    send(5, 6, 7, 8);
    @(negedge clk);
    chk("pre_rst_full", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_pr", int'(pr), 0);
    chk("mrst_pi", int'(pi), 0);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with random downstream stalls.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
               int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
